// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: CPU data bus, video write stream and keyboard strobe of the Hack data-memory controller.
interface data_mem_ctrl_if #(
    parameter int DW     = 16,
    parameter int AW     = 15,
    parameter int SCR_AW = 13
);
    logic [AW-1:0]     addressM;
    logic              writeM;
    logic [DW-1:0]     outM;
    logic [DW-1:0]     inM;
    logic              vid_valid;
    logic [SCR_AW-1:0] vid_addr;
    logic [DW-1:0]     vid_data;
    logic              vid_ready;
    logic              kbd_valid;
    logic [DW-1:0]     kbd_code;
    logic              scr_ovf;

    modport master (
        output addressM, writeM, outM, vid_ready, kbd_valid, kbd_code,
        input  inM, vid_valid, vid_addr, vid_data, scr_ovf
    );

    modport slave (
        input  addressM, writeM, outM, vid_ready, kbd_valid, kbd_code,
        output inM, vid_valid, vid_addr, vid_data, scr_ovf
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: Hack data-side memory map (RAM, screen shadow, keyboard) with a
// posted FIFO that forwards screen writes to the video subsystem.
module data_mem_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 15,
    parameter int RAM_AW = 14,
    parameter int SCR_AW = 13,
    parameter int FD     = 4
) (
    input logic              clk50m,
    input logic              rst_n,
    input logic              en25m,
    data_mem_ctrl_if.slave   bus
);
    localparam int PW = $clog2(FD);

    logic [DW-1:0]     ram       [2**RAM_AW];
    logic [DW-1:0]     shadow    [2**SCR_AW];
    logic [DW-1:0]     fifo_data [FD];
    logic [SCR_AW-1:0] fifo_addr [FD];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [DW-1:0] inm_q, inm_d, kbd_q, kbd_d;
    logic          ovf_q, ovf_d;
    logic          is_ram, is_scr, is_kbd, ram_wr, scr_wr, full, empty, push, pop;
    logic [DW-1:0] rd_data;

    always_comb begin
        is_ram   = !bus.addressM[AW-1];
        is_scr   = bus.addressM[AW-1 -: 2] == 2'b10;
        is_kbd   = bus.addressM == AW'(16'h6000);
        rd_data  = is_ram ? ram[bus.addressM[RAM_AW-1:0]]
                 : is_scr ? shadow[bus.addressM[SCR_AW-1:0]]
                 : is_kbd ? kbd_q : '0;
        ram_wr   = en25m && bus.writeM && is_ram;
        scr_wr   = en25m && bus.writeM && is_scr;
        empty    = count_q == '0;
        full     = count_q == (PW+1)'(FD);
        pop      = !empty && bus.vid_ready;
        // A full FIFO still accepts a push when its head leaves on the same edge.
        push     = scr_wr && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + 1'b1
                 : (pop && !push) ? count_q - 1'b1 : count_q;
        ovf_d    = ovf_q || (scr_wr && full && !pop);
        // Reads sample mid CPU cycle so inM is settled by the next en25m edge.
        inm_d    = en25m ? inm_q : rd_data;
        kbd_d    = bus.kbd_valid ? bus.kbd_code : kbd_q;
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            inm_q    <= '0;
            kbd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            inm_q    <= inm_d;
            kbd_q    <= kbd_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk50m) begin
        if (ram_wr) ram[bus.addressM[RAM_AW-1:0]] <= bus.outM;
        if (scr_wr) shadow[bus.addressM[SCR_AW-1:0]] <= bus.outM;
        if (push) begin
            fifo_addr[wr_ptr_q] <= bus.addressM[SCR_AW-1:0];
            fifo_data[wr_ptr_q] <= bus.outM;
        end
    end

    assign bus.inM       = inm_q;
    assign bus.vid_valid = !empty;
    assign bus.vid_addr  = empty ? '0 : fifo_addr[rd_ptr_q];
    assign bus.vid_data  = empty ? '0 : fifo_data[rd_ptr_q];
    assign bus.scr_ovf   = ovf_q;
endmodule
